regfile_wb_arbiter: RTL and testbench

Shares the register file's single write port (we3/wa3/wd3) between two writeback requesters: requester A (single-cycle ALU writeback) and requester B (multi-cycle load/multiply writeback). Each requester uses a valid/ready handshake. One request is granted per cycle by 2-way round-robin, then registered onto the write port. The block sits between the execute/memory stages and the register file, and exports a saturating conflict counter for performance monitoring.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/regfile_wb_arbiter_rr_arb2.sv | 44 ++++
 rtl/regfile_wb_arbiter.sv | 109 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Purpose: shared types and defaults for the register-file writeback arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package regfile_pkg;

    localparam int XLEN_DEFAULT   = 32;
    localparam int REG_AW_DEFAULT = 5;

    // Encoding of the round-robin pointer: which requester was served last.
    localparam logic LAST_A = 1'b0;
    localparam logic LAST_B = 1'b1;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_A    = 2'd1,
        GNT_B    = 2'd2
    } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Purpose: 2-request round-robin arbiter with an internal last-served pointer.
// Latency: grant is combinational from req; pointer updates on the clock edge.
// Backpressure: none of its own; a grant is issued only while rst is low.
//
// Ports:
//   clk, rst   rising-edge clock, synchronous active-high reset
//   req[1:0]   request vector, bit 0 = A, bit 1 = B
//   gnt[1:0]   one-hot grant, same bit order as req
module rr_arb2
    import regfile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last;

    always_comb begin
        gnt = 2'b00;
        if (!rst) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                // Contention: serve whoever was not served most recently.
                2'b11:   gnt = (last == LAST_B) ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Every grant is a transfer, so the pointer follows the grant directly.
    always_ff @(posedge clk) begin
        if (rst) begin
            last <= LAST_B;
        end else if (gnt[0]) begin
            last <= LAST_A;
        end else if (gnt[1]) begin
            last <= LAST_B;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Purpose: shares the register file write port between ALU (A) and load/mul (B) writeback.
// Latency: handshake to registered we3/wa3/wd3 is 1 cycle; 1 write per cycle sustained.
// Backpressure: valid/ready per requester; the round-robin loser sees ready=0 and retries.
//
// Ports:
//   clk, rst                      rising-edge clock, synchronous active-high reset
//   a_valid/a_ready/a_rd/a_data   requester A writeback handshake
//   b_valid/b_ready/b_rd/b_data   requester B writeback handshake
//   we3/wa3/wd3                   registered register-file write port
//   conflict_cnt                  saturating count of cycles with both requesters valid
// Build option: REGFILE_WB_X0_DROP_EN makes rd=0 requests complete immediately
// without a write and without touching the round-robin pointer.
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [REG_AW-1:0] a_rd,
    input  logic [XLEN-1:0]   a_data,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [REG_AW-1:0] b_rd,
    input  logic [XLEN-1:0]   b_data,
    output logic              we3,
    output logic [REG_AW-1:0] wa3,
    output logic [XLEN-1:0]   wd3,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       a_drop;
    logic       b_drop;
    logic [1:0] req;
    logic [1:0] gnt;
    gnt_e       gnt_sel;

`ifdef REGFILE_WB_X0_DROP_EN
    // Writes to x0 are discarded here so they never occupy the write port.
    assign a_drop = a_valid && (a_rd == '0);
    assign b_drop = b_valid && (b_rd == '0);
`else
    assign a_drop = 1'b0;
    assign b_drop = 1'b0;
`endif

    // Dropped requests stay out of arbitration, so they cannot move the pointer.
    assign req = {b_valid && !b_drop, a_valid && !a_drop};

    rr_arb2 u_arb (
        .clk (clk),
        .rst (rst),
        .req (req),
        .gnt (gnt)
    );

    assign a_ready = !rst && (gnt[0] || a_drop);
    assign b_ready = !rst && (gnt[1] || b_drop);

    always_comb begin
        gnt_sel = GNT_NONE;
        if (gnt[0]) begin
            gnt_sel = GNT_A;
        end else if (gnt[1]) begin
            gnt_sel = GNT_B;
        end
    end

    // Address/data hold when idle; only we3 drops back to 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            we3 <= 1'b0;
            wa3 <= '0;
            wd3 <= '0;
        end else begin
            case (gnt_sel)
                GNT_A: begin
                    we3 <= 1'b1;
                    wa3 <= a_rd;
                    wd3 <= a_data;
                end
                GNT_B: begin
                    we3 <= 1'b1;
                    wa3 <= b_rd;
                    wd3 <= b_data;
                end
                default: begin
                    we3 <= 1'b0;
                end
            endcase
        end
    end

    // Counts contention by valids, regardless of whether a request was dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (a_valid && b_valid && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Purpose: self-checking bench for regfile_wb_arbiter (model compare plus directed literals).
// Latency: n/a.
// Backpressure: n/a.
module tb_regfile_wb_arbiter;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    localparam int CNT_W  = 16;
    localparam int CMAX   = (1 << CNT_W) - 1;

`ifdef REGFILE_WB_X0_DROP_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              a_valid, b_valid;
    logic              a_ready, b_ready;
    logic [REG_AW-1:0] a_rd, b_rd;
    logic [XLEN-1:0]   a_data, b_data;
    logic              we3;
    logic [REG_AW-1:0] wa3;
    logic [XLEN-1:0]   wd3;
    logic [CNT_W-1:0]  conflict_cnt;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rd         (a_rd),
        .a_data       (a_data),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rd         (b_rd),
        .b_data       (b_data),
        .we3          (we3),
        .wa3          (wa3),
        .wd3          (wd3),
        .conflict_cnt (conflict_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: who was served last, what the write port shows, and the counter.
    bit              m_on   = 1'b0;
    bit              m_lastb = 1'b1;      // 1: B served last (reset state)
    bit              m_we   = 1'b0;
    logic [REG_AW-1:0] m_wa = '0;
    logic [XLEN-1:0] m_wd   = '0;
    int              m_cnt  = 0;
    int              win;                 // 0 none, 1 A, 2 B
    bit              a_el, b_el, a_dr, b_dr, ea, eb;

    always @(negedge clk) begin
        if (m_on) begin
            a_dr = DROP && a_valid && (a_rd == 0);
            b_dr = DROP && b_valid && (b_rd == 0);
            a_el = a_valid && !a_dr;
            b_el = b_valid && !b_dr;
            win = 0;
            if (a_el && b_el)  win = m_lastb ? 1 : 2;
            else if (a_el)     win = 1;
            else if (b_el)     win = 2;
            if (rst) win = 0;
            ea = !rst && ((win == 1) || a_dr);
            eb = !rst && ((win == 2) || b_dr);

            chk("m_a_ready", 64'(a_ready), 64'(ea));
            chk("m_b_ready", 64'(b_ready), 64'(eb));
            chk("m_we3", 64'(we3), 64'(m_we));
            chk("m_wa3", 64'(wa3), 64'(m_wa));
            chk("m_wd3", 64'(wd3), 64'(m_wd));
            chk("m_cnt", 64'(conflict_cnt), 64'(m_cnt));

            if (rst) begin
                m_we = 0; m_wa = '0; m_wd = '0; m_cnt = 0; m_lastb = 1'b1;
            end else begin
                if (win == 1) begin
                    m_we = 1; m_wa = a_rd; m_wd = a_data; m_lastb = 1'b0;
                end else if (win == 2) begin
                    m_we = 1; m_wa = b_rd; m_wd = b_data; m_lastb = 1'b1;
                end else begin
                    m_we = 0;
                end
                if (a_valid && b_valid && m_cnt < CMAX) m_cnt = m_cnt + 1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 0;
        b_valid = 0;
        rst = 1;
        step();
        rst = 0;
    endtask

    initial begin
        rst = 1; a_valid = 0; b_valid = 0;
        a_rd = '0; b_rd = '0; a_data = '0; b_data = '0;
        step();
        m_on = 1'b1;
        step();
        rst = 0;
        #1;
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_wa3", 64'(wa3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_cnt", 64'(conflict_cnt), 64'd0);

        // Single A write.
        a_valid = 1; a_rd = 5; a_data = 32'hDEADBEEF;
        #1;
        chk("t1_a_ready", 64'(a_ready), 64'd1);
        chk("t1_b_ready", 64'(b_ready), 64'd0);
        step();
        a_valid = 0;
        #1;
        chk("t1_we3", 64'(we3), 64'd1);
        chk("t1_wa3", 64'(wa3), 64'd5);
        chk("t1_wd3", 64'(wd3), 64'hDEADBEEF);
        step();
        #1;
        chk("t1_we3_off", 64'(we3), 64'd0);

        // Continuous contention: A, B, A, B.
        do_reset();
        a_valid = 1; a_rd = 1; a_data = 32'h11;
        b_valid = 1; b_rd = 2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_a_ready", 64'(a_ready), 64'(i % 2 == 0));
            chk("t2_b_ready", 64'(b_ready), 64'(i % 2 == 1));
            step();
        end
        a_valid = 0; b_valid = 0;
        #1;
        chk("t2_cnt", 64'(conflict_cnt), 64'd4);
        chk("t2_wa3", 64'(wa3), 64'd2);
        chk("t2_wd3", 64'(wd3), 64'h22);

        // Same destination from both: winner then loser.
        do_reset();
        a_valid = 1; a_rd = 7; a_data = 32'h1;
        b_valid = 1; b_rd = 7; b_data = 32'h2;
        #1;
        chk("t3_a_ready", 64'(a_ready), 64'd1);
        chk("t3_b_ready", 64'(b_ready), 64'd0);
        step();
        a_valid = 0;
        #1;
        chk("t3_b_ready2", 64'(b_ready), 64'd1);
        chk("t3_wa3_1", 64'(wa3), 64'd7);
        chk("t3_wd3_1", 64'(wd3), 64'h1);
        step();
        b_valid = 0;
        #1;
        chk("t3_we3_2", 64'(we3), 64'd1);
        chk("t3_wa3_2", 64'(wa3), 64'd7);
        chk("t3_wd3_2", 64'(wd3), 64'h2);

        // Reset in the middle of a pending B request.
        do_reset();
        a_valid = 1; a_rd = 4; a_data = 32'h44;
        b_valid = 1; b_rd = 9; b_data = 32'h99;
        step();
        a_valid = 0;
        rst = 1;
        #1;
        chk("t5_b_ready_rst", 64'(b_ready), 64'd0);
        chk("t5_a_ready_rst", 64'(a_ready), 64'd0);
        step();
        rst = 0;
        #1;
        chk("t5_we3", 64'(we3), 64'd0);
        chk("t5_cnt", 64'(conflict_cnt), 64'd0);
        chk("t5_b_ready", 64'(b_ready), 64'd1);
        step();
        b_valid = 0;
        #1;
        chk("t5_we3_b", 64'(we3), 64'd1);
        chk("t5_wa3_b", 64'(wa3), 64'd9);
        chk("t5_wd3_b", 64'(wd3), 64'h99);

        // rd=0 from A alongside B rd=3.
        do_reset();
        a_valid = 1; a_rd = 0; a_data = 32'hAA;
        b_valid = 1; b_rd = 3; b_data = 32'h33;
        #1;
        if (DROP) begin
            chk("t6_a_ready", 64'(a_ready), 64'd1);
            chk("t6_b_ready", 64'(b_ready), 64'd1);
            step();
            a_valid = 0; b_valid = 0;
            #1;
            chk("t6_we3", 64'(we3), 64'd1);
            chk("t6_wa3", 64'(wa3), 64'd3);
            chk("t6_wd3", 64'(wd3), 64'h33);
            a_valid = 1; a_rd = 0; a_data = 32'h5;
            #1;
            chk("t6_x0_ready", 64'(a_ready), 64'd1);
            step();
            a_valid = 0;
            #1;
            chk("t6_x0_we3", 64'(we3), 64'd0);
        end else begin
            chk("t6_a_ready", 64'(a_ready), 64'd1);
            chk("t6_b_ready", 64'(b_ready), 64'd0);
            step();
            a_valid = 0;
            #1;
            chk("t6_we3", 64'(we3), 64'd1);
            chk("t6_wa3", 64'(wa3), 64'd0);
            chk("t6_wd3", 64'(wd3), 64'hAA);
            step();
            b_valid = 0;
            #1;
            chk("t6_wa3_b", 64'(wa3), 64'd3);
        end

        // Counter saturation.
        do_reset();
        a_valid = 1; a_rd = 1; a_data = 32'h11;
        b_valid = 1; b_rd = 2; b_data = 32'h22;
        repeat (CMAX + 4) step();
        a_valid = 0; b_valid = 0;
        #1;
        chk("t4_cnt_sat", 64'(conflict_cnt), 64'hFFFF);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
